simon_ctrl: RTL and testbench

SIMON_CTRL -- requirements
Module: simon_ctrl

---
 rtl/simon_ctrl.sv | 147 ++++++++++++++
 tb/tb_simon_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_ctrl.sv
// Simon memory-game controller: LFSR colour source, show/gap sequencer, replay checker.
// Optional input-idle timeout in INPUT is compiled in with `define SIMON_TIMEOUT_EN.
module simon_ctrl #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       colour_in,
  input  logic [1:0] colour_val,
  output logic       led_valid,
  output logic [1:0] led_colour,
  output logic       input_ready,
  output logic [4:0] level,
  output logic       game_over,
  output logic       win
);

  // One shared timer covers show, gap and (optionally) input-idle counting.
  localparam int TSG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX = (TSG > TIMEOUT_CYCLES) ? TSG : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_SHOW, S_GAP, S_INPUT, S_WIN, S_LOSE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q;
  logic [31:0]   seq_q, seq_d;
  logic [4:0]    level_q, level_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          led_valid_q, input_ready_q, game_over_q, win_q;
  logic [1:0]    led_colour_q, led_colour_d;
  logic          last, show_d;
  logic [1:0]    cur;

  assign last = (({1'b0, idx_q} + 5'd1) == level_q);
  assign cur  = seq_q[{idx_q, 1'b0} +: 2];

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    level_d = level_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_GEN;
          seq_d   = '0;
          level_d = '0;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      S_GEN: begin
        seq_d[{level_q[3:0], 1'b0} +: 2] = lfsr_q[1:0];
        level_d = level_q + 5'd1;
        idx_d   = '0;
        tmr_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (tmr_q == TW'(SHOW_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == TW'(GAP_CYCLES - 1)) begin
          tmr_d = '0;
          if (last) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SHOW;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_INPUT: begin
        if (colour_in) begin
          tmr_d = '0;
          if (colour_val != cur)            state_d = S_LOSE;
          else if (last)                    state_d = (level_q == 5'(MAX_LEN)) ? S_WIN : S_GEN;
          else                              idx_d   = idx_q + 4'd1;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_LOSE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign show_d       = (state_d == S_SHOW);
  assign led_colour_d = show_d ? seq_d[{idx_d, 1'b0} +: 2] : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 16'hACE1;
      seq_q         <= '0;
      level_q       <= '0;
      idx_q         <= '0;
      tmr_q         <= '0;
      led_valid_q   <= 1'b0;
      led_colour_q  <= 2'd0;
      input_ready_q <= 1'b0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      seq_q         <= seq_d;
      level_q       <= level_d;
      idx_q         <= idx_d;
      tmr_q         <= tmr_d;
      led_valid_q   <= show_d;
      led_colour_q  <= led_colour_d;
      input_ready_q <= (state_d == S_INPUT);
      game_over_q   <= (state_d == S_WIN) || (state_d == S_LOSE);
      win_q         <= (state_d == S_WIN);
    end
  end

  assign led_valid   = led_valid_q;
  assign led_colour  = led_colour_q;
  assign input_ready = input_ready_q;
  assign level       = level_q;
  assign game_over   = game_over_q;
  assign win         = win_q;

endmodule

// File: tb/tb_simon_ctrl.sv
// Self-checking bench for simon_ctrl: vector table, round scoreboard, reset/lose/win/timeout sequences.
module tb_simon_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 0, cin_a = 0, start_b = 0, cin_b = 0;
  logic [1:0] cval_a = 0, cval_b = 0;
  logic       lv_a, ir_a, go_a, win_a, lv_b, ir_b, go_b, win_b;
  logic [1:0] lc_a, lc_b;
  logic [4:0] lvl_a, lvl_b;

  simon_ctrl #(.MAX_LEN(16), .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .colour_in(cin_a), .colour_val(cval_a),
    .led_valid(lv_a), .led_colour(lc_a), .input_ready(ir_a), .level(lvl_a),
    .game_over(go_a), .win(win_a));

  simon_ctrl #(.MAX_LEN(2), .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .colour_in(cin_b), .colour_val(cval_b),
    .led_valid(lv_b), .led_colour(lc_b), .input_ready(ir_b), .level(lvl_b),
    .game_over(go_b), .win(win_b));

  logic       use_b = 1'b0;
  logic       m_lv, m_ir, m_go, m_win;
  logic [1:0] m_lc;
  logic [4:0] m_lvl;
  assign m_lv  = use_b ? lv_b  : lv_a;
  assign m_lc  = use_b ? lc_b  : lc_a;
  assign m_ir  = use_b ? ir_b  : ir_a;
  assign m_go  = use_b ? go_b  : go_a;
  assign m_win = use_b ? win_b : win_a;
  assign m_lvl = use_b ? lvl_b : lvl_a;

  // Reference colour source: both DUTs share clock and reset, so one model serves both.
  logic [15:0] ref_lfsr;
  always @(posedge clk or posedge rst)
    if (rst) ref_lfsr <= 16'hACE1;
    else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};

  int n_cmp = 0, n_bad = 0;
  logic [1:0] seq_m [16];
  logic [1:0] exp_q [$];

  typedef struct {
    logic       s, c;
    logic [1:0] v;
    logic       ev, eir, ego, ewin;
    logic [4:0] elvl;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic c, input logic [1:0] v);
    if (use_b) begin start_b = s; cin_b = c; cval_b = v; end
    else       begin start_a = s; cin_a = c; cval_a = v; end
  endtask

  task automatic press(input logic [1:0] v);
    drive(1'b0, 1'b1, v);
    step();
    drive(1'b0, 1'b0, 2'd0);
  endtask

  // Expected colours are queued when the round starts and popped as each is displayed.
  task automatic show_round(input int lvl);
    int w, n, g;
    logic [1:0] e;
    for (int i = 0; i < lvl; i++) exp_q.push_back(seq_m[i]);
    for (int i = 0; i < lvl; i++) begin
      w = 0;
      while (m_lv !== 1'b1 && w < 40) begin step(); w++; end
      if (m_lv !== 1'b1) begin
        chk("show_wait", m_lv, 1);
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      chk("led_colour", m_lc, e);
      chk("level_show", m_lvl, lvl);
      n = 0;
      while (m_lv === 1'b1 && n < 20) begin n++; step(); end
      chk("show_len", n, 4);
      if (i < lvl - 1) begin
        g = 0;
        while (m_lv !== 1'b1 && g < 20) begin chk("gap_colour", m_lc, 0); g++; step(); end
        chk("gap_len", g, 2);
      end
    end
    w = 0;
    while (m_ir !== 1'b1 && w < 40) begin w++; step(); end
    chk("gap_to_input", w, 2);
    chk("input_ready", m_ir, 1);
    chk("go_in_round", m_go, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           s  c  v     ev eir ego ewin lvl
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[1]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[5]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[6]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[10] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1};

    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    chk("idle_lv", lv_a, 0);  chk("idle_lc", lc_a, 0);  chk("idle_ir", ir_a, 0);
    chk("idle_go", go_a, 0);  chk("idle_win", win_a, 0); chk("idle_lvl", lvl_a, 0);

    // Start plus round-1 display with strobes landing in IDLE/GEN/SHOW/GAP.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].s, tbl[i].c, tbl[i].v);
      step();
      if (i == 3) seq_m[0] = ref_lfsr[1:0];
      chk($sformatf("tbl%0d_lv", i),  lv_a,  tbl[i].ev);
      chk($sformatf("tbl%0d_lc", i),  lc_a,  tbl[i].ev ? seq_m[0] : 2'd0);
      chk($sformatf("tbl%0d_ir", i),  ir_a,  tbl[i].eir);
      chk($sformatf("tbl%0d_go", i),  go_a,  tbl[i].ego);
      chk($sformatf("tbl%0d_win", i), win_a, tbl[i].ewin);
      chk($sformatf("tbl%0d_lvl", i), lvl_a, tbl[i].elvl);
    end
    drive(1'b0, 1'b0, 2'd0);

    // Rounds 2 and 3 with correct echo.
    press(seq_m[0]);
    seq_m[1] = ref_lfsr[1:0];
    chk("r1_gen_ir", ir_a, 0);
    show_round(2);
    press(seq_m[0]);
    chk("r2_mid_ir", ir_a, 1);
    press(seq_m[1]);
    seq_m[2] = ref_lfsr[1:0];
    show_round(3);
    press(seq_m[0]); press(seq_m[1]); press(seq_m[2]);
    seq_m[3] = ref_lfsr[1:0];
    chk("r3_go", go_a, 0);
    chk("r3_lvl", lvl_a, 3);

    // Asynchronous reset while SHOW is active.
    step(); step();
    chk("pre_rst_lv", lv_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_lv", lv_a, 0);   chk("rst_lvl", lvl_a, 0); chk("rst_ir", ir_a, 0);
    chk("rst_go", go_a, 0);   chk("rst_lc", lc_a, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_lv", lv_a, 0);
    chk("post_rst_lvl", lvl_a, 0);

    // Wrong second press in round 2.
    drive(1'b1, 1'b0, 2'd0); step();
    seq_m[0] = ref_lfsr[1:0];
    drive(1'b0, 1'b0, 2'd0);
    show_round(1);
    press(seq_m[0]);
    seq_m[1] = ref_lfsr[1:0];
    show_round(2);
    press(seq_m[0]);
    press(seq_m[1] ^ 2'd1);
    chk("lose_go", go_a, 1);  chk("lose_win", win_a, 0);
    chk("lose_lvl", lvl_a, 2); chk("lose_ir", ir_a, 0);
    press(seq_m[0]);
    step(); step();
    chk("lose_hold_go", go_a, 1);
    chk("lose_hold_lvl", lvl_a, 2);

    // Idle player in INPUT.
    drive(1'b1, 1'b0, 2'd0); step();
    seq_m[0] = ref_lfsr[1:0];
    drive(1'b0, 1'b0, 2'd0);
    show_round(1);
`ifdef SIMON_TIMEOUT_EN
    repeat (19) step();
    chk("to_before_ir", ir_a, 1);
    chk("to_before_go", go_a, 0);
    step();
    chk("to_go", go_a, 1);
    chk("to_ir", ir_a, 0);
    chk("to_win", win_a, 0);
`else
    repeat (100) step();
    chk("noto_ir", ir_a, 1);
    chk("noto_go", go_a, 0);
`endif

    // MAX_LEN=2 instance: win, start coinciding with the terminal press, restart.
    use_b = 1'b1;
    drive(1'b1, 1'b0, 2'd0); step();
    seq_m[0] = ref_lfsr[1:0];
    drive(1'b0, 1'b0, 2'd0);
    show_round(1);
    press(seq_m[0]);
    seq_m[1] = ref_lfsr[1:0];
    chk("b_gen_win", win_b, 0);
    show_round(2);
    press(seq_m[0]);
    drive(1'b1, 1'b1, seq_m[1]); step();
    chk("b_win", win_b, 1);   chk("b_go", go_b, 1);
    chk("b_lvl", lvl_b, 2);   chk("b_ir", ir_b, 0);
    drive(1'b1, 1'b0, 2'd0); step();
    seq_m[0] = ref_lfsr[1:0];
    drive(1'b0, 1'b0, 2'd0);
    chk("b_restart_win", win_b, 0);
    chk("b_restart_go", go_b, 0);
    chk("b_restart_lvl", lvl_b, 0);
    show_round(1);
    press(seq_m[0]);
    chk("b_r1_win", win_b, 0);
    chk("b_r1_lvl", lvl_b, 1);
    chk("b_r1_ir", ir_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
